// File: rtl/freq_meas_ctrl_if.sv
// Result channel of the period-counting frequency meter: averaged period plus timeout flag,
// moved under valid/ready flow control.
`timescale 1ns/1ps
interface freq_meas_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] per_data;
  logic             per_valid;
  logic             per_ready;
  logic             timeout;

  modport master (output per_data, output per_valid, output timeout, input per_ready);
  modport slave  (input per_data, input per_valid, input timeout, output per_ready);
endinterface

// File: rtl/freq_meas_ctrl.sv
// Sequencer for the period-counting frequency meter: synchronises sig_in, averages 2^AVG_LOG2
// edge-to-edge periods and hands one result per request. Option macro: AUTO_REARM_EN.
`timescale 1ns/1ps
module freq_meas_ctrl #(
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sig_in,
  input  logic                start,
  output logic                busy,
  output logic [1:0]          dbg_state_o,
  freq_meas_ctrl_if.master    res_if
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_MEAS = 2'd2, S_DONE = 2'd3} state_e;

  localparam int NAVG  = 1 << AVG_LOG2;
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;

  state_e             state_q, state_d;
  logic               sync1_q, sync_q, prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]   per_data_q, per_data_d;
  logic               timeout_q, timeout_d;

  logic               sig_edge;
  logic               at_limit;
  logic               last_period;
  logic [ACC_W-1:0]   acc_sum;
  logic               hs;
  logic               rearm;

  assign sig_edge    = sync_q & ~prev_q;
  assign at_limit    = (cnt_q == CNT_W'(TIMEOUT));
  assign last_period = (n_q == N_W'(NAVG - 1));
  assign acc_sum     = acc_q + ACC_W'(cnt_q);
  // Result channel: a transfer happens on a cycle where per_valid & per_ready are both 1;
  // per_valid, per_data and timeout never change while per_valid=1 and per_ready=0.
  assign hs          = (state_q == S_DONE) & res_if.per_ready;

`ifdef AUTO_REARM_EN
  assign rearm = 1'b1;
`else
  assign rearm = start;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      n_q        <= '0;
      per_data_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      sync1_q    <= sig_in;
      sync_q     <= sync1_q;
      prev_q     <= sync_q;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      per_data_q <= per_data_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        if (sig_edge)      state_d = S_MEAS;
        else if (at_limit) state_d = S_DONE;
      end
      S_MEAS: begin
        // A coincident edge at the timeout limit still counts as a valid period.
        if (sig_edge && last_period) state_d = S_DONE;
        else if (!sig_edge && at_limit) state_d = S_DONE;
      end
      S_DONE: if (hs) state_d = rearm ? S_ARM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    n_d        = n_q;
    per_data_d = per_data_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: if (start) cnt_d = CNT_W'(1);
      S_ARM: begin
        if (sig_edge) begin
          cnt_d = CNT_W'(1);
          acc_d = '0;
          n_d   = '0;
        end else if (at_limit) begin
          per_data_d = '0;
          timeout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MEAS: begin
        if (sig_edge) begin
          cnt_d = CNT_W'(1);
          acc_d = acc_sum;
          n_d   = n_q + N_W'(1);
          if (last_period) begin
            per_data_d = CNT_W'(acc_sum >> AVG_LOG2);
            timeout_d  = 1'b0;
          end
        end else if (at_limit) begin
          per_data_d = '0;
          timeout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: if (hs && rearm) cnt_d = CNT_W'(1);
      default: ;
    endcase
  end

  // per_valid is DONE itself, so it rises the cycle after the deciding edge like a register would.
  always_comb begin
    busy             = (state_q != S_IDLE);
    dbg_state_o      = state_q;
    res_if.per_valid = (state_q == S_DONE);
    res_if.per_data  = per_data_q;
    res_if.timeout   = timeout_q;
  end

endmodule
